div_err_accum: RTL and testbench



---
 rtl/div_metrics_pkg.sv | 32 +++
 rtl/div_err_stage.sv | 45 ++++
 rtl/div_err_accum.sv | 187 ++++++++++++++++++
 tb/tb_div_err_accum.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_metrics_pkg.sv
// Shared definitions for the divider error-metric collector: FSM states,
// default widths and the saturating add used by every accumulator.
package div_metrics_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_ACC_W = 40;

  // Adds two values (both already below 2**width) and clamps the sum at
  // 2**width-1. Bit 64 of the result is the saturation flag, bits 63:0 the
  // clamped sum. Valid for width 1..63.
  function automatic logic [64:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [63:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = 64'((65'd1 << width) - 65'd1);
    if (sum > {1'b0, lim}) begin
      return {1'b1, lim};
    end
    return {1'b0, sum[63:0]};
  endfunction

endpackage

// File: rtl/div_err_stage.sv
// Registered first pipeline stage: magnitude of the difference of one value
// pair plus inequality flags for two value pairs.
module div_err_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] a_exact,
  input  logic [W-1:0] a_approx,
  input  logic [W-1:0] b_exact,
  input  logic [W-1:0] b_approx,
  output logic         out_valid,
  output logic [W-1:0] abs_diff,
  output logic         a_neq,
  output logic         b_neq
);

  logic signed [W:0] diff;
  logic [W-1:0]      mag;

  // Signed difference in W+1 bits; its magnitude always fits in W bits.
  always_comb begin
    diff = $signed({1'b0, a_exact}) - $signed({1'b0, a_approx});
    mag  = diff[W] ? W'(-diff) : W'(diff);
  end

  // Stage register; data only moves when a sample enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      abs_diff  <= '0;
      a_neq     <= 1'b0;
      b_neq     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        abs_diff <= mag;
        a_neq    <= (a_exact != a_approx);
        b_neq    <= (b_exact != b_approx);
      end
    end
  end

endmodule

// File: rtl/div_err_accum.sv
// Error-metric collector for approximate dividers. Over a run of N samples it
// accumulates squared and absolute quotient error, the maximum absolute error
// and quotient/remainder mismatch counts, saturating every figure.
//
// Handshake: a sample transfers on a rising edge where in_valid and in_ready
// are both high; in_ready depends only on registered state, in_valid must not
// depend on in_ready, and the sample fields are ignored when in_valid is low.
//
// Pipeline: S1 (div_err_stage) captures |q diff| and the flags on the
// handshake edge k; a product register forms the square at k+1; the
// accumulators update at k+2. Nothing in the pipeline stalls.
module div_err_accum
  import div_metrics_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     q_exact,
  input  logic [W-1:0]     q_approx,
  input  logic [W-1:0]     r_exact,
  input  logic [W-1:0]     r_approx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_sq_err,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [W-1:0]     max_abs_err,
  output logic [CNT_W-1:0] q_mismatch,
  output logic [CNT_W-1:0] r_mismatch,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  state_t           state, state_nx;
  logic             done_nx;
  logic [CNT_W-1:0] n_q, accepted;
  logic             take, start_ok, last_take;

  logic             s1_valid, s1_qneq, s1_rneq;
  logic [W-1:0]     s1_abs;
  logic             s2_valid, s2_qneq, s2_rneq;
  logic [W-1:0]     s2_abs;
  logic [2*W-1:0]   s2_sq;

  logic [64:0]      sq_res, abs_res, qm_res, rm_res;
  logic             sq_hit, abs_hit, qm_hit, rm_hit;

  assign state_dbg = state;
  assign in_ready  = (state == ST_RUN) && (accepted < n_q);
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign take      = in_valid && in_ready;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_take = take && (CNT_W'(accepted + 1'b1) == n_q);

  // Next-state and done-pulse decode.
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          if (num_samples == '0) begin
            state_nx = ST_DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (last_take) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        // With S1 empty, only the last sample is left in the product
        // register and it lands in the accumulators on this edge.
        if (!s1_valid) begin
          state_nx = ST_DONE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
    end
  end

  // Run length latch and accepted-sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      accepted <= '0;
    end else if (start_ok) begin
      n_q      <= num_samples;
      accepted <= '0;
    end else if (take) begin
      accepted <= accepted + 1'b1;
    end
  end

  div_err_stage #(.W(W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (take),
    .a_exact   (q_exact),
    .a_approx  (q_approx),
    .b_exact   (r_exact),
    .b_approx  (r_approx),
    .out_valid (s1_valid),
    .abs_diff  (s1_abs),
    .a_neq     (s1_qneq),
    .b_neq     (s1_rneq)
  );

  // Product register: square of the S1 magnitude, carried with its flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sq    <= '0;
      s2_abs   <= '0;
      s2_qneq  <= 1'b0;
      s2_rneq  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sq   <= (2*W)'(s1_abs) * (2*W)'(s1_abs);
        s2_abs  <= s1_abs;
        s2_qneq <= s1_qneq;
        s2_rneq <= s1_rneq;
      end
    end
  end

  // Saturating sums. The clamped result never has bits set above the
  // accumulator width, so OR-ing them into the hit flag changes nothing.
  always_comb begin
    sq_res  = sat_add(64'(sum_sq_err),  64'(s2_sq),   ACC_W);
    abs_res = sat_add(64'(sum_abs_err), 64'(s2_abs),  ACC_W);
    qm_res  = sat_add(64'(q_mismatch),  64'(s2_qneq), CNT_W);
    rm_res  = sat_add(64'(r_mismatch),  64'(s2_rneq), CNT_W);
    sq_hit  = sq_res[64]  | (|sq_res[63:ACC_W]);
    abs_hit = abs_res[64] | (|abs_res[63:ACC_W]);
    qm_hit  = qm_res[64]  | (|qm_res[63:CNT_W]);
    rm_hit  = rm_res[64]  | (|rm_res[63:CNT_W]);
  end

  // Accumulators: cleared by an accepted start, updated per drained sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_sq_err  <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      q_mismatch  <= '0;
      r_mismatch  <= '0;
      overflow    <= 1'b0;
    end else if (start_ok) begin
      sum_sq_err  <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      q_mismatch  <= '0;
      r_mismatch  <= '0;
      overflow    <= 1'b0;
    end else if (s2_valid) begin
      sum_sq_err  <= sq_res[ACC_W-1:0];
      sum_abs_err <= abs_res[ACC_W-1:0];
      q_mismatch  <= qm_res[CNT_W-1:0];
      r_mismatch  <= rm_res[CNT_W-1:0];
      if (s2_abs > max_abs_err) max_abs_err <= s2_abs;
      if (sq_hit || abs_hit || qm_hit || rm_hit) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_err_accum.sv
// Directed bench for div_err_accum: a table of single runs with hand-computed
// results, then hand-written sequences for reset, handshake, N=0, saturation
// and start-while-busy.
module tb_div_err_accum;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [7:0]  q_exact, q_approx, r_exact, r_approx;

  logic        in_ready, busy, done, overflow;
  logic [39:0] sum_sq_err, sum_abs_err;
  logic [7:0]  max_abs_err;
  logic [15:0] q_mismatch, r_mismatch;
  logic [1:0]  state_dbg;

  logic        in_ready16, busy16, done16, overflow16;
  logic [15:0] sum_sq16, sum_abs16;
  logic [7:0]  max_abs16;
  logic [15:0] q_mm16, r_mm16;
  logic [1:0]  state16;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  div_err_accum dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready),
    .q_exact(q_exact), .q_approx(q_approx), .r_exact(r_exact), .r_approx(r_approx),
    .busy(busy), .done(done), .sum_sq_err(sum_sq_err), .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err), .q_mismatch(q_mismatch), .r_mismatch(r_mismatch),
    .overflow(overflow), .state_dbg(state_dbg)
  );

  div_err_accum #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready16),
    .q_exact(q_exact), .q_approx(q_approx), .r_exact(r_exact), .r_approx(r_approx),
    .busy(busy16), .done(done16), .sum_sq_err(sum_sq16), .sum_abs_err(sum_abs16),
    .max_abs_err(max_abs16), .q_mismatch(q_mm16), .r_mismatch(r_mm16),
    .overflow(overflow16), .state_dbg(state16)
  );

  // ---------------- scoring ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic [15:0] n);
    @(negedge clk);
    start       = 1'b1;
    num_samples = n;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [7:0] qe, input logic [7:0] qa,
                       input logic [7:0] re, input logic [7:0] ra);
    in_valid = v;
    q_exact  = qe;
    q_approx = qa;
    r_exact  = re;
    r_approx = ra;
  endtask

  // Waits at negedges for done, bounded; returns negedges waited.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " sum_sq"},   sum_sq_err,  0);
    check({tag, " sum_abs"},  sum_abs_err, 0);
    check({tag, " max_abs"},  max_abs_err, 0);
    check({tag, " q_mm"},     q_mismatch,  0);
    check({tag, " r_mm"},     r_mismatch,  0);
    check({tag, " overflow"}, overflow,    0);
  endtask

  // ---------------- vector table ----------------
  // Sample i of a record lives in element [i] of the packed arrays.
  typedef struct {
    int               n;
    logic [2:0][7:0]  qe, qa, re, ra;
    logic [39:0]      sq, ab;
    logic [7:0]       mx;
    logic [15:0]      qm, rm;
  } vec_t;

  vec_t tv[4];

  initial begin
    int cyc;

    // exact match: every metric stays 0
    tv[0].n = 3;
    tv[0].qe = {8'd255, 8'd10, 8'd5};  tv[0].qa = {8'd255, 8'd10, 8'd5};
    tv[0].re = {8'd0, 8'd2, 8'd1};     tv[0].ra = {8'd0, 8'd2, 8'd1};
    tv[0].sq = 0; tv[0].ab = 0; tv[0].mx = 0; tv[0].qm = 0; tv[0].rm = 0;
    // known error: 3^2+5^2=34, 3+5=8, max 5
    tv[1].n = 2;
    tv[1].qe = {8'd0, 8'd3, 8'd10};    tv[1].qa = {8'd0, 8'd8, 8'd7};
    tv[1].re = {8'd0, 8'd1, 8'd1};     tv[1].ra = {8'd0, 8'd1, 8'd1};
    tv[1].sq = 34; tv[1].ab = 8; tv[1].mx = 5; tv[1].qm = 2; tv[1].rm = 0;
    // remainder-only mismatch
    tv[2].n = 1;
    tv[2].qe = {8'd0, 8'd0, 8'd4};     tv[2].qa = {8'd0, 8'd0, 8'd4};
    tv[2].re = {8'd0, 8'd0, 8'd1};     tv[2].ra = {8'd0, 8'd0, 8'd0};
    tv[2].sq = 0; tv[2].ab = 0; tv[2].mx = 0; tv[2].qm = 0; tv[2].rm = 1;
    // mixed: errors 255,100,0 -> 65025+10000=75025, 355, max 255
    tv[3].n = 3;
    tv[3].qe = {8'd7, 8'd200, 8'd0};   tv[3].qa = {8'd7, 8'd100, 8'd255};
    tv[3].re = {8'd5, 8'd1, 8'd3};     tv[3].ra = {8'd6, 8'd2, 8'd3};
    tv[3].sq = 75025; tv[3].ab = 355; tv[3].mx = 255; tv[3].qm = 2; tv[3].rm = 2;

    rst_n = 1'b0;
    start = 1'b0;
    num_samples = '0;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check_all_zero("reset");
    check("reset state", state_dbg, 0);
    check("reset in_ready", in_ready, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);

    // table-driven runs
    for (int t = 0; t < 4; t++) begin
      do_start(16'(tv[t].n));
      check($sformatf("t%0d busy", t), busy, 1);
      for (int i = 0; i < tv[t].n; i++) begin
        drive(1'b1, tv[t].qe[i], tv[t].qa[i], tv[t].re[i], tv[t].ra[i]);
        check($sformatf("t%0d in_ready s%0d", t, i), in_ready, 1);
        @(negedge clk);
      end
      drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
      check($sformatf("t%0d in_ready after last", t), in_ready, 0);
      wait_done(cyc);
      check($sformatf("t%0d done latency", t), cyc, 2);
      check($sformatf("t%0d sum_sq", t),  sum_sq_err,  tv[t].sq);
      check($sformatf("t%0d sum_abs", t), sum_abs_err, tv[t].ab);
      check($sformatf("t%0d max_abs", t), max_abs_err, tv[t].mx);
      check($sformatf("t%0d q_mm", t),    q_mismatch,  tv[t].qm);
      check($sformatf("t%0d r_mm", t),    r_mismatch,  tv[t].rm);
      check($sformatf("t%0d overflow", t), overflow,   0);
      check($sformatf("t%0d busy at done", t), busy,   0);
      @(negedge clk);
      check($sformatf("t%0d done pulse width", t), done, 0);
      check($sformatf("t%0d held sum_sq", t), sum_sq_err, tv[t].sq);
    end

    // reset mid-run: two samples of error 3 accumulated, then async reset
    do_start(16'd4);
    drive(1'b1, 8'd10, 8'd7, 8'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    check("midrst pre sum_sq", sum_sq_err, 18);
    check("midrst pre busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    check("midrst state", state_dbg, 0);
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) cyc++;
    end
    check("midrst no done", cyc, 0);
    check("midrst idle", state_dbg, 0);

    // handshake: in_valid 1,0,1,1 with N=2; the fourth sample is dropped
    do_start(16'd2);
    drive(1'b1, 8'd9, 8'd1, 8'd0, 8'd0);
    check("hs ready c0", in_ready, 1);
    @(negedge clk);
    drive(1'b0, 8'd50, 8'd0, 8'd0, 8'd0);
    check("hs ready c1", in_ready, 1);
    @(negedge clk);
    drive(1'b1, 8'd2, 8'd5, 8'd0, 8'd0);
    check("hs ready c2", in_ready, 1);
    @(negedge clk);
    drive(1'b1, 8'd100, 8'd0, 8'd0, 8'd0);
    check("hs ready c3", in_ready, 0);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    wait_done(cyc);
    check("hs done seen", done, 1);
    check("hs sum_sq", sum_sq_err, 73);
    check("hs sum_abs", sum_abs_err, 11);
    check("hs max_abs", max_abs_err, 8);
    check("hs q_mm", q_mismatch, 2);
    @(negedge clk);

    // N=0: done on the cycle after start, results cleared
    do_start(16'd0);
    check("n0 done", done, 1);
    check_all_zero("n0");
    check("n0 busy", busy, 0);
    @(negedge clk);
    check("n0 done pulse width", done, 0);

    // saturation with start pulsed (N=0) during RUN, which must be ignored
    do_start(16'd2);
    drive(1'b1, 8'd255, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    drive(1'b1, 8'd0, 8'd255, 8'd0, 8'd0);
    start = 1'b1;
    num_samples = 16'd0;
    @(negedge clk);
    start = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    check("sat busy after ignored start", busy, 1);
    wait_done(cyc);
    check("sat done latency", cyc, 2);
    check("sat16 sum_sq", sum_sq16, 65535);
    check("sat16 overflow", overflow16, 1);
    check("sat16 sum_abs", sum_abs16, 510);
    check("sat16 q_mm", q_mm16, 2);
    check("sat40 sum_sq", sum_sq_err, 130050);
    check("sat40 overflow", overflow, 0);
    @(negedge clk);

    // new start after DONE clears the sticky overflow
    do_start(16'd1);
    check("restart overflow16", overflow16, 0);
    check("restart sum_sq16", sum_sq16, 0);
    drive(1'b1, 8'd1, 8'd1, 8'd2, 8'd2);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    wait_done(cyc);
    check("restart done latency", cyc, 2);
    check("restart overflow16 end", overflow16, 0);
    check("restart q_mm16", q_mm16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
